// File: rtl/sdram_readback.sv
// sdram_readback: reads NWORDS words from the SDRAM controller host port and streams them out
// through a small valid/ready FIFO. Define READBACK_CHECK_EN to add the ROM compare ports.
module sdram_readback #(
    parameter int                ADDR_W     = 24,
    parameter int                DATA_W     = 16,
    parameter int                NWORDS     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              host_intf_rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_o,
    output logic [ADDR_W-1:0] addr_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              done_i,
    input  logic              rdpending_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i
`ifdef READBACK_CHECK_EN
    ,
    output logic [11:0]       rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              err_o,
    output logic [11:0]       err_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NWORDS) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_STALL = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]        state;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              start_accept;
    logic              push;
    logic              pop;
    logic              unused_rdpending;

    // Pending status from the controller is informational; the done_i handshake is authoritative.
    assign unused_rdpending = rdpending_i;

    assign busy_o = (state != S_IDLE) && (state != S_FIN);
    assign done_o = (state == S_FIN);

    // NOTE: combinational logic uses blocking '='; state registers below use non-blocking '<='.
    // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        start_accept = (state == S_IDLE) && start_i;
        push         = (state == S_REQ) && rd_o && done_i;
        pop          = valid_o && ready_i;
        count_next   = count + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_next  = rd_ptr + PTR_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (host_intf_rst_i) begin
            state  <= S_IDLE;
            rd_o   <= 1'b0;
            addr_o <= '0;
            index  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_accept) begin
                        index  <= '0;
                        addr_o <= BASE_ADDR;
                        if (count == FULL_CNT) begin
                            state <= S_STALL;
                        end else begin
                            state <= S_REQ;
                            rd_o  <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // rd_o low here is the mandatory gap cycle between two requests
                    if (!rd_o) begin
                        rd_o <= 1'b1;
                    end else if (done_i) begin
                        rd_o   <= 1'b0;
                        index  <= index + IDX_W'(1);
                        addr_o <= addr_o + ADDR_W'(1);
                        if (index == LAST_IDX) begin
                            state <= S_DRAIN;
                        end else if (count_next == FULL_CNT) begin
                            state <= S_STALL;
                        end
                    end
                end
                S_STALL: begin
                    if (count != FULL_CNT) begin
                        state <= S_REQ;
                        rd_o  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (count == '0) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    rd_o  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; count/valid_o alone say which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (host_intf_rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_ptr_next;
            count   <= count_next;
            valid_o <= (count_next != '0);
            // Incoming word becomes the head only when nothing older survives this cycle
            if (push && (count_next == CNT_W'(1))) begin
                data_o <= data_i;
            end else if (pop && (count_next != '0)) begin
                data_o <= mem[rd_ptr_next];
            end
        end
    end

`ifdef READBACK_CHECK_EN
    assign rom_addr_o = 12'(index);

    always_ff @(posedge clk) begin
        if (host_intf_rst_i || start_accept) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else if (push && (data_i != DATA_W'(rom_data_i))) begin
            err_o <= 1'b1;
            if (err_cnt_o != 12'hFFF) begin
                err_cnt_o <= err_cnt_o + 12'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_readback.sv
// tb_sdram_readback: scoreboard bench for sdram_readback with a 3-cycle SDRAM responder model.
// A second instance with a near-top base address exercises address wrap.
module tb_sdram_readback;

    localparam int          NW     = 8;
    localparam int          DEPTH  = 4;
    localparam logic [23:0] BASE   = 24'h000100;
    localparam int          W_NW   = 4;
    localparam logic [23:0] W_BASE = 24'hFFFFFE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, busy, done, rd, done_i, rdpend, valid, ready;
    logic [23:0] addr;
    logic [15:0] data_i, data_o;
    logic        w_start, w_busy, w_done, w_rd, w_done_i, w_valid, w_ready;
    logic [23:0] w_addr;
    logic [15:0] w_data_i, w_data_o;
`ifdef READBACK_CHECK_EN
    logic [11:0] rom_addr, err_cnt, w_rom_addr, w_err_cnt;
    logic [15:0] rom_data, w_rom_data;
    logic        err, w_err;
    assign rom_data   = {4'h0, rom_addr};
    assign w_rom_data = {4'h0, w_rom_addr};
`endif

    sdram_readback #(
        .ADDR_W(24), .DATA_W(16), .NWORDS(NW), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .host_intf_rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .rd_o(rd), .addr_o(addr), .data_i(data_i), .done_i(done_i), .rdpending_i(rdpend),
        .data_o(data_o), .valid_o(valid), .ready_i(ready)
`ifdef READBACK_CHECK_EN
        , .rom_addr_o(rom_addr), .rom_data_i(rom_data), .err_o(err), .err_cnt_o(err_cnt)
`endif
    );

    sdram_readback #(
        .ADDR_W(24), .DATA_W(16), .NWORDS(W_NW), .BASE_ADDR(W_BASE), .FIFO_DEPTH(DEPTH)
    ) u_wrap (
        .clk(clk), .host_intf_rst_i(rst), .start_i(w_start), .busy_o(w_busy), .done_o(w_done),
        .rd_o(w_rd), .addr_o(w_addr), .data_i(w_data_i), .done_i(w_done_i), .rdpending_i(rdpend),
        .data_o(w_data_o), .valid_o(w_valid), .ready_i(w_ready)
`ifdef READBACK_CHECK_EN
        , .rom_addr_o(w_rom_addr), .rom_data_i(w_rom_data), .err_o(w_err), .err_cnt_o(w_err_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          k, rises, rd_wait, spur_used, words, dones;
    logic        prev_rd, spur_en, corrupt5;
    logic [23:0] exp_addr;
    logic [15:0] exp_q [$];
    int          w_k, w_wait, w_words;
    logic [15:0] w_exp_q [$];
    logic [23:0] w_addrs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Word returned by the SDRAM model for the idx-th read of a run.
    function automatic logic [15:0] sd_word(input int idx);
`ifdef READBACK_CHECK_EN
        return 16'(idx);
`else
        return 16'(32'hA5C3 ^ (idx * 32'h1111));
`endif
    endfunction

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_done: got no done_o pulse, expected one within %0d cycles", name, budget);
        end else begin
            check({name, "_busy_at_done"}, busy, 0);
        end
    endtask

    // SDRAM responder for u_dut: done_i three cycles after rd_o rises; issues expected data.
    always @(negedge clk) begin
        if (rst) begin
            done_i  = 1'b0;
            data_i  = '0;
            rd_wait = 0;
            prev_rd = 1'b0;
            exp_q.delete();
        end else begin
            if (start && !busy && !done) begin
                k         = 0;
                rises     = 0;
                spur_used = 0;
            end
            if (rd && !prev_rd) rises++;
            prev_rd = rd;
            if (!rd) begin
                rd_wait = 0;
                if (spur_en && busy && spur_used < 3) begin
                    done_i = 1'b1;
                    data_i = 16'hDEAD;
                    spur_used++;
                end else begin
                    done_i = 1'b0;
                end
            end else begin
                done_i = 1'b0;
                rd_wait++;
                if (rd_wait == 3) begin
                    rd_wait  = 0;
                    exp_addr = BASE + 24'(k);
                    check("addr", addr, exp_addr);
                    data_i = sd_word(k);
                    if (corrupt5 && k == 5) data_i = data_i ^ 16'h0040;
                    exp_q.push_back(data_i);
                    done_i = 1'b1;
                    k++;
                end
            end
        end
    end

    // Output monitor for u_dut: pops the scoreboard on every accepted beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (start && !busy && !done) begin
                words = 0;
                dones = 0;
            end
            if (done) dones++;
            if (valid && ready) begin
                words++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data: got 0x%0h, expected no word", data_o);
                end else begin
                    check("data", data_o, exp_q.pop_front());
                end
            end
        end
    end

    // Responder and monitor for the wrap instance.
    always @(negedge clk) begin
        if (rst) begin
            w_done_i = 1'b0;
            w_data_i = '0;
            w_wait   = 0;
        end else begin
            if (w_start && !w_busy && !w_done) begin
                w_k     = 0;
                w_words = 0;
            end
            if (!w_rd) begin
                w_done_i = 1'b0;
                w_wait   = 0;
            end else begin
                w_done_i = 1'b0;
                w_wait++;
                if (w_wait == 3) begin
                    w_wait = 0;
                    w_addrs.push_back(w_addr);
                    w_data_i = sd_word(w_k);
                    w_exp_q.push_back(w_data_i);
                    w_done_i = 1'b1;
                    w_k++;
                end
            end
            if (w_valid && w_ready) begin
                w_words++;
                if (w_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w_data: got 0x%0h, expected no word", w_data_o);
                end else begin
                    check("w_data", w_data_o, w_exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] w_exp_addr [4];
        int n;
        w_exp_addr = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
        rst      = 1'b1;
        start    = 1'b0;
        ready    = 1'b1;
        rdpend   = 1'b0;
        spur_en  = 1'b0;
        corrupt5 = 1'b0;
        w_start  = 1'b0;
        w_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", rd, 0);
        check("rst_valid", valid, 0);
        check("rst_addr", addr, 0);
        check("rst_data", data_o, 0);

        // T1: full run with a free-flowing consumer; start during FIN must be ignored
        pulse_start();
        wait_done("t1", 300);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("t1_words", words, 8);
        check("t1_dones", dones, 1);
        check("t1_reads", rises, 8);
        check("t1_busy_after", busy, 0);
        check("t1_left_in_queue", exp_q.size(), 0);

        // T2: consumer stalled, FIFO fills after exactly DEPTH reads
        ready = 1'b0;
        pulse_start();
        repeat (60) @(negedge clk);
        check("t2_reads_stalled", rises, 4);
        check("t2_rd_stalled", rd, 0);
        check("t2_valid_stalled", valid, 1);
        check("t2_busy_stalled", busy, 1);
        @(posedge clk);
        #1 ready = 1'b1;
        wait_done("t2", 300);
        repeat (4) @(negedge clk);
        check("t2_words", words, 8);
        check("t2_reads", rises, 8);
        check("t2_dones", dones, 1);

        // T3: reset while a read is outstanding, then a clean restart
        pulse_start();
        n = 0;
        while (!(k >= 3 && rd) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t3_rd_before_rst", rd, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t3_rd_after_rst", rd, 0);
        check("t3_valid_after_rst", valid, 0);
        check("t3_busy_after_rst", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_start();
        wait_done("t3", 300);
        repeat (4) @(negedge clk);
        check("t3_words", words, 8);
        check("t3_reads", rises, 8);
        check("t3_dones", dones, 1);

        // T4: start pulses while busy and done_i while rd_o is low
        pulse_start();
        repeat (6) @(negedge clk);
        check("t4_busy", busy, 1);
        spur_en = 1'b1;
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        wait_done("t4", 300);
        spur_en = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_words", words, 8);
        check("t4_reads", rises, 8);
        check("t4_dones", dones, 1);

`ifdef READBACK_CHECK_EN
        // T6: word 5 corrupted, then a clean rerun clears the flags
        corrupt5 = 1'b1;
        pulse_start();
        wait_done("t6", 300);
        repeat (2) @(negedge clk);
        check("t6_err", err, 1);
        check("t6_err_cnt", err_cnt, 1);
        corrupt5 = 1'b0;
        pulse_start();
        check("t6_err_cleared", err, 0);
        check("t6_cnt_cleared", err_cnt, 0);
        wait_done("t6_clean", 300);
        repeat (2) @(negedge clk);
        check("t6_clean_err", err, 0);
        check("t6_clean_cnt", err_cnt, 0);
`endif

        // T5: address wrap past 0xFFFFFF
        @(posedge clk);
        #1 w_start = 1'b1;
        @(posedge clk);
        #1 w_start = 1'b0;
        n = 0;
        while (!w_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!w_done) begin
            checks++;
            errors++;
            $display("FAIL t5_done: got no done_o pulse, expected one within 300 cycles");
        end
        repeat (3) @(negedge clk);
        check("t5_words", w_words, 4);
        check("t5_nreads", w_addrs.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < w_addrs.size()) check($sformatf("t5_addr%0d", i), w_addrs[i], w_exp_addr[i]);
        end
        check("t5_busy_after", w_busy, 0);
`ifdef READBACK_CHECK_EN
        check("t5_err", w_err, 0);
        check("t5_err_cnt", w_err_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
